nxn_fp_matmul: RTL and testbench
================================

// Module: nxn_fp_matmul
// PURPOSE
//  Parametrised NxN single-precision matrix multiplier, Res = A*B (or Res += A*B).
//  Generalises the fixed 4x4 float multiplier: matrix is split into 2x2 tiles and one
//  pipelined 2x2 tile multiply-accumulate unit is time-shared under an FSM.
//  Sits behind the matrix-op top level; start/busy/done handshake, operands latched on start.
// PARAMETERS
//  N           4   matrix dimension; even, >=2
//  FLOAT_SIZE  32  element width (IEEE-754 single); only 32 supported
//  MAC_LAT     3   latency of tile_mac2x2 in cycles, >=1
// PORTS
//  clk         in   1                   rising-edge clock
//  reset       in   1                   synchronous, active-high
//  start       in   1                   request; accepted only when busy=0
//  accumulate  in   1                   sampled with start: 0 -> Res=A*B, 1 -> Res=Res+A*B
//  A           in   N*N*FLOAT_SIZE      row-major, elem(r,c) at [(r*N+c)*32 +: 32]
//  B           in   N*N*FLOAT_SIZE      same layout
//  busy        out  1                   operation in progress
//  done        out  1                   one-cycle pulse, Res valid
//  Res         out  N*N*FLOAT_SIZE      registered result, same layout
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Reset: busy=0, done=0, Res=all 0, FSM=IDLE.
//  - States: IDLE -> (start) ISSUE -> WAIT -> ISSUE ... -> DONE -> IDLE.
//  - Cycle 0: start=1 & busy=0: A, B, accumulate latched; busy=1 from cycle 1.
//  - Tile loop order: ti (row tile) outer, tj, then k innermost; T = (N/2)^3 steps.
//  - Step s issues {A(ti,k), B(k,tj), C} to tile_mac2x2 in ISSUE; C = +0.0 tile when k=0
//    and accumulate=0, Res tile(ti,tj) when k=0 and accumulate=1, else previous MAC output.
//  - Issue cycles: 1 + s*MAC_LAT; WAIT counts MAC_LAT-1 cycles; result of last k of a tile
//    written to Res tile(ti,tj) on its arrival edge; intermediate tiles never visible on Res.
//  - done=1 (busy=0) in cycle 2 + T*MAC_LAT exactly; N=4,MAC_LAT=3 -> cycle 26.
//  - Res holds value until next accepted start completes a tile; untouched tiles keep value.
//  - start while busy=1: ignored, no effect on latched operands. start during done cycle: accepted.
//  - A/B/accumulate may change freely after the start cycle.
//  - Reset mid-operation: abort immediately, Res cleared, no done pulse; in-flight MAC result discarded.
//  - FP semantics (rounding, NaN, denormals) are those of tile_mac2x2; block adds no arithmetic.
//  - Counters ti,tj,k sized $clog2(N/2) (min 1 bit); wrap only at N/2-1 -> 0 with carry to next.
// STRUCTURE
//  - matmul_pkg: FLOAT_SIZE, FP_ZERO=32'h0, FP_ONE=32'h3F800000, FSM state enum, tile index helper.
//  - Sub-module tile_mac2x2 (clk, reset, in_valid, a/b/c 4x32, out_valid, res 4x32), fully
//    pipelined, latency MAC_LAT; nxn_fp_matmul holds FSM, counters, tile select/writeback muxes.
// TESTING
//  1. N=4, A=I (diag 3F800000), B=0x3F800000..(1..16.0), accumulate=0 -> Res==B, done at cycle 26.
//  2. N=4, A,B all 1.0, accumulate=0 -> every Res elem 0x40800000 (4.0); repeat with accumulate=1
//     -> every elem 0x41000000 (8.0).
//  3. start pulsed at cycles 5 and 12 with different A during run -> ignored; result from cycle-0 A only.
//  4. reset asserted at cycle 10 of a run -> busy=0, Res=0 next cycle, no done; new start completes normally.
//  5. N=2, MAC_LAT=1, A=[1,2;3,4], B=[5,6;7,8] -> Res=[19,22;43,50] (0x41980000,0x41B00000,
//     0x422C0000,0x42480000), done at cycle 3.
//  6. Back-to-back: start asserted in done cycle -> accepted, busy=1 next cycle, second done after T*MAC_LAT+2.

Source files
------------

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared constants, FSM state type and tile indexing for the NxN float multiplier
//
// Purpose: element width, float constants, controller state encoding and a
// helper that maps (tile row, tile col, row-in-tile, col-in-tile) to the
// row-major element index of an NxN matrix.
package matmul_pkg;

   localparam int          FLOAT_SIZE = 32;
   localparam logic [31:0] FP_ZERO    = 32'h0000_0000;
   localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
   localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   // Row-major element index of element (r,c) inside 2x2 tile (tr,tc).
   function automatic int elem_idx(input int n, input int tr, input int tc,
                                   input int r, input int c);
      return (tr * 2 + r) * n + tc * 2 + c;
   endfunction

endpackage

// File: rtl/tile_mac2x2.sv
// rtl/tile_mac2x2.sv - pipelined 2x2 single-precision tile multiply-accumulate
//
// Purpose: res = c + a*b on 2x2 tiles of IEEE-754 singles, fixed latency.
// Each element is ((c + a(i,0)*b(0,j)) + a(i,1)*b(1,j)), round-to-nearest-even
// per operation; denormal inputs and results are flushed to signed zero.
// Ports:
//   clk, reset        clock, synchronous active-high reset (clears valids)
//   in_valid          operands present this cycle
//   a, b, c           2x2 tiles, element (r,c) at index r*2+c
//   out_valid, res    result tile, MAC_LAT cycles after in_valid
module tile_mac2x2 #(
   parameter int MAC_LAT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [3:0][31:0] a,
   input  logic [3:0][31:0] b,
   input  logic [3:0][31:0] c,
   output logic             out_valid,
   output logic [3:0][31:0] res
);
   import matmul_pkg::*;

   function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
      logic              s, g, st, rnd;
      logic [7:0]        ex, ey;
      logic [47:0]       p;
      logic [23:0]       m;
      logic [24:0]       mr;
      logic signed [9:0] e;
      s  = x[31] ^ y[31];
      ex = x[30:23];
      ey = y[30:23];
      if ((ex == 8'hFF && x[22:0] != 23'h0) || (ey == 8'hFF && y[22:0] != 23'h0))
         return FP_QNAN;
      if (ex == 8'hFF || ey == 8'hFF) begin
         if (ex == 8'h00 || ey == 8'h00) return FP_QNAN;
         return {s, 8'hFF, 23'h0};
      end
      if (ex == 8'h00 || ey == 8'h00) return {s, 31'h0};
      p = {24'h0, 1'b1, x[22:0]} * {24'h0, 1'b1, y[22:0]};
      e = $signed({2'b00, ex}) + $signed({2'b00, ey}) - 10'sd127;
      if (p[47]) begin
         m  = p[47:24];
         g  = p[23];
         st = |p[22:0];
         e  = e + 10'sd1;
      end else begin
         m  = p[46:23];
         g  = p[22];
         st = |p[21:0];
      end
      rnd = g & (st | m[0]);
      mr  = {1'b0, m} + 25'(rnd);
      if (mr[24]) begin
         mr = mr >> 1;
         e  = e + 10'sd1;
      end
      if (e >= 10'sd255) return {s, 8'hFF, 23'h0};
      if (e <= 10'sd0)   return {s, 31'h0};
      return {s, e[7:0], mr[22:0]};
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
      logic [31:0]       hi, lo;
      logic [7:0]        ex, ey, d8;
      logic [26:0]       mh, ml, mls;
      logic [27:0]       sum;
      logic [23:0]       m;
      logic [24:0]       mr;
      logic              s, g, st, rnd;
      logic signed [9:0] e;
      ex = x[30:23];
      ey = y[30:23];
      if ((ex == 8'hFF && x[22:0] != 23'h0) || (ey == 8'hFF && y[22:0] != 23'h0))
         return FP_QNAN;
      if (ex == 8'hFF && ey == 8'hFF) return (x[31] != y[31]) ? FP_QNAN : x;
      if (ex == 8'hFF) return x;
      if (ey == 8'hFF) return y;
      if (ex == 8'h00 && ey == 8'h00) return {x[31] & y[31], 31'h0};
      if (ex == 8'h00) return y;
      if (ey == 8'h00) return x;
      if (x[30:0] >= y[30:0]) begin
         hi = x;
         lo = y;
      end else begin
         hi = y;
         lo = x;
      end
      d8 = hi[30:23] - lo[30:23];
      mh = {1'b1, hi[22:0], 3'b000};
      ml = {1'b1, lo[22:0], 3'b000};
      // Three extra low bits act as guard/round/sticky through alignment.
      if (d8 >= 8'd27) begin
         mls = 27'd1;
      end else begin
         mls    = ml >> d8;
         mls[0] = mls[0] | (|(ml & ((27'd1 << d8) - 27'd1)));
      end
      s = hi[31];
      e = $signed({2'b00, hi[30:23]});
      if (hi[31] == lo[31]) begin
         sum = {1'b0, mh} + {1'b0, mls};
         if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            e   = e + 10'sd1;
         end
      end else begin
         sum = {1'b0, mh} - {1'b0, mls};
         if (sum == 28'h0) return FP_ZERO;
         for (int i = 0; i < 27; i++) begin
            if (!sum[26]) begin
               sum = sum << 1;
               e   = e - 10'sd1;
            end
         end
      end
      m   = sum[26:3];
      g   = sum[2];
      st  = sum[1] | sum[0];
      rnd = g & (st | m[0]);
      mr  = {1'b0, m} + 25'(rnd);
      if (mr[24]) begin
         mr = mr >> 1;
         e  = e + 10'sd1;
      end
      if (e >= 10'sd255) return {s, 8'hFF, 23'h0};
      if (e <= 10'sd0)   return {s, 31'h0};
      return {s, e[7:0], mr[22:0]};
   endfunction

   logic [3:0][31:0]              sum;
   logic [MAC_LAT-1:0][3:0][31:0] pipe_d;
   logic [MAC_LAT-1:0]            pipe_v;

   always_comb begin
      sum = '0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            sum[2'(i * 2 + j)] = fp_add(fp_add(c[2'(i * 2 + j)],
                                               fp_mul(a[2'(i * 2)], b[2'(j)])),
                                        fp_mul(a[2'(i * 2 + 1)], b[2'(2 + j)]));
         end
      end
   end

   // Arithmetic is one combinational cloud followed by MAC_LAT register
   // stages, leaving retiming free to balance the pipeline.
   generate
      if (MAC_LAT == 1) begin : g_lat1
         always_ff @(posedge clk) begin
            if (reset) pipe_v <= '0;
            else       pipe_v <= in_valid;
            pipe_d <= sum;
         end
      end else begin : g_latn
         always_ff @(posedge clk) begin
            if (reset) pipe_v <= '0;
            else       pipe_v <= {pipe_v[MAC_LAT-2:0], in_valid};
            pipe_d <= {pipe_d[MAC_LAT-2:0], sum};
         end
      end
   endgenerate

   assign out_valid = pipe_v[MAC_LAT-1];
   assign res       = pipe_d[MAC_LAT-1];

endmodule

// File: rtl/nxn_fp_matmul.sv
// rtl/nxn_fp_matmul.sv - NxN single-precision matrix multiply(-accumulate) on a shared 2x2 tile MAC
//
// Purpose: Res = A*B or Res = Res + A*B, iterating 2x2 tiles (ti, tj, k
// innermost) through one pipelined tile_mac2x2.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start, accumulate  request (taken when busy=0) and its mode
//   A, B               row-major operands, latched on an accepted start
//   busy, done         operation in progress / one-cycle completion pulse
//   Res                registered result, row-major
module nxn_fp_matmul #(
   parameter int N          = 4,
   parameter int FLOAT_SIZE = matmul_pkg::FLOAT_SIZE,
   parameter int MAC_LAT    = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      accumulate,
   input  logic [N*N*FLOAT_SIZE-1:0] A,
   input  logic [N*N*FLOAT_SIZE-1:0] B,
   output logic                      busy,
   output logic                      done,
   output logic [N*N*FLOAT_SIZE-1:0] Res
);
   import matmul_pkg::*;

   localparam int NT  = N / 2;
   localparam int CW  = (NT > 1) ? $clog2(NT) : 1;
   localparam int WCW = $clog2(MAC_LAT + 1);
   localparam logic [CW-1:0]  TMAX      = CW'(NT - 1);
   localparam logic [WCW-1:0] WAIT_MID  = WCW'(MAC_LAT - 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAC_LAT);

   state_t                    state, state_nxt;
   logic [N*N*FLOAT_SIZE-1:0] a_q, b_q;
   logic                      acc_q;
   logic [CW-1:0]             ti, tj, k;
   logic [CW-1:0]             wb_ti, wb_tj;
   logic                      wb_last;
   logic [WCW-1:0]            wait_cnt;
   logic                      draining;
   logic                      accept, last_step;
   logic                      mac_in_valid, mac_out_valid;
   logic [3:0][31:0]          mac_a, mac_b, mac_c, mac_res;

   assign accept    = start && !busy;
   assign last_step = (ti == TMAX) && (tj == TMAX) && (k == TMAX);

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // The final step waits one extra cycle so its result lands before DONE.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (start) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = (last_step || MAC_LAT > 1) ? ST_WAIT : ST_ISSUE;
         ST_WAIT: begin
            if (wait_cnt == (draining ? WAIT_LAST : WAIT_MID))
               state_nxt = draining ? ST_DONE : ST_ISSUE;
         end
         ST_DONE:  state_nxt = start ? ST_ISSUE : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy         = 1'b0;
      done         = 1'b0;
      mac_in_valid = 1'b0;
      unique case (state)
         ST_ISSUE: begin
            busy         = 1'b1;
            mac_in_valid = 1'b1;
         end
         ST_WAIT:  busy = 1'b1;
         ST_DONE:  done = 1'b1;
         default:  ;
      endcase
   end

   // Tile select: C seeds from zero or the current Res tile on k=0, otherwise
   // chains the MAC output arriving in this same issue cycle.
   always_comb begin
      mac_a = '0;
      mac_b = '0;
      mac_c = '0;
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 2; c++) begin
            mac_a[2'(r * 2 + c)] = a_q[elem_idx(N, int'(ti), int'(k), r, c) * FLOAT_SIZE +: FLOAT_SIZE];
            mac_b[2'(r * 2 + c)] = b_q[elem_idx(N, int'(k), int'(tj), r, c) * FLOAT_SIZE +: FLOAT_SIZE];
            if (k != '0)
               mac_c[2'(r * 2 + c)] = mac_res[2'(r * 2 + c)];
            else if (acc_q)
               mac_c[2'(r * 2 + c)] = Res[elem_idx(N, int'(ti), int'(tj), r, c) * FLOAT_SIZE +: FLOAT_SIZE];
            else
               mac_c[2'(r * 2 + c)] = FP_ZERO;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= 1'b0;
         ti       <= '0;
         tj       <= '0;
         k        <= '0;
         wb_ti    <= '0;
         wb_tj    <= '0;
         wb_last  <= 1'b0;
         wait_cnt <= '0;
         draining <= 1'b0;
         Res      <= '0;
      end else begin
         if (accept) begin
            a_q      <= A;
            b_q      <= B;
            acc_q    <= accumulate;
            ti       <= '0;
            tj       <= '0;
            k        <= '0;
            draining <= 1'b0;
         end
         if (state == ST_ISSUE) begin
            // Only one tile is ever in flight, so its destination rides along here.
            wb_ti    <= ti;
            wb_tj    <= tj;
            wb_last  <= (k == TMAX);
            draining <= last_step;
            wait_cnt <= WCW'(1);
            if (k == TMAX) begin
               k <= '0;
               if (tj == TMAX) begin
                  tj <= '0;
                  ti <= (ti == TMAX) ? '0 : ti + CW'(1);
               end else begin
                  tj <= tj + CW'(1);
               end
            end else begin
               k <= k + CW'(1);
            end
         end
         if (state == ST_WAIT)
            wait_cnt <= wait_cnt + WCW'(1);
         if (mac_out_valid && wb_last) begin
            for (int r = 0; r < 2; r++) begin
               for (int c = 0; c < 2; c++) begin
                  Res[elem_idx(N, int'(wb_ti), int'(wb_tj), r, c) * FLOAT_SIZE +: FLOAT_SIZE]
                     <= mac_res[2'(r * 2 + c)];
               end
            end
         end
      end
   end

   tile_mac2x2 #(
      .MAC_LAT (MAC_LAT)
   ) u_mac (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (mac_in_valid),
      .a         (mac_a),
      .b         (mac_b),
      .c         (mac_c),
      .out_valid (mac_out_valid),
      .res       (mac_res)
   );

endmodule

// File: tb/tb_nxn_fp_matmul.sv
// tb/tb_nxn_fp_matmul.sv - self-checking bench for nxn_fp_matmul (N=4/MAC_LAT=3 and N=2/MAC_LAT=1)
module tb_nxn_fp_matmul;
   import matmul_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         reset = 1'b1;
   logic         start4 = 1'b0, acc4 = 1'b0, busy4, done4;
   logic [511:0] a4 = '0, b4 = '0, res4;
   logic         start2 = 1'b0, acc2 = 1'b0, busy2, done2;
   logic [127:0] a2 = '0, b2 = '0, res2;

   nxn_fp_matmul #(.N(4), .FLOAT_SIZE(32), .MAC_LAT(3)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .accumulate(acc4),
      .A(a4), .B(b4), .busy(busy4), .done(done4), .Res(res4));

   nxn_fp_matmul #(.N(2), .FLOAT_SIZE(32), .MAC_LAT(1)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .accumulate(acc2),
      .A(a2), .B(b2), .busy(busy2), .done(done2), .Res(res2));

   int n_cmp = 0;
   int n_bad = 0;
   int ma[16], mb[16], mr[16];

   function automatic logic [31:0] i2f(input int v);
      int          m, msb;
      logic [31:0] mm;
      if (v == 0) return FP_ZERO;
      m   = (v < 0) ? -v : v;
      msb = 0;
      for (int i = 0; i < 31; i++) if ((m >> i) != 0) msb = i;
      mm = 32'(m) << (23 - msb);
      return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + msb), mm[22:0]};
   endfunction

   function automatic logic [511:0] pack4(input int m[16]);
      logic [511:0] v;
      for (int e = 0; e < 16; e++) v[e*32 +: 32] = i2f(m[e]);
      return v;
   endfunction

   task automatic rand_mats();
      for (int e = 0; e < 16; e++) begin
         ma[e] = int'($urandom_range(16)) - 8;
         mb[e] = int'($urandom_range(16)) - 8;
      end
   endtask

   task automatic model_step(input bit acc);
      int t[16];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            t[r*4+c] = acc ? mr[r*4+c] : 0;
            for (int kk = 0; kk < 4; kk++) t[r*4+c] += ma[r*4+kk] * mb[kk*4+c];
         end
      mr = t;
   endtask

   // Start on dut4 (cycle 0) and run until done; operands are scrambled after
   // cycle 0 and start is re-pulsed at cycles p1/p2.
   task automatic run4(input logic [511:0] av, input logic [511:0] bv, input bit acc,
                       input bit in_place, input int p1, input int p2,
                       output int dc, output logic b1, output logic bd);
      int cyc;
      if (!in_place) begin
         @(posedge clk); #1;
      end
      a4 = av; b4 = bv; acc4 = acc; start4 = 1'b1;
      cyc = 0; dc = -1; b1 = 1'b0; bd = 1'b1;
      while (cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         start4 = (cyc == p1 || cyc == p2);
         a4 = {16{$urandom()}};
         b4 = {16{$urandom()}};
         acc4 = 1'($urandom_range(1));
         if (cyc == 1) b1 = busy4;
         if (done4) begin
            dc = cyc;
            bd = busy4;
            break;
         end
      end
      start4 = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL reset_busy4: got %b want 0", busy4); end
      n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL reset_done4: got %b want 0", done4); end
      n_cmp++; if (res4 !== '0) begin n_bad++; $display("FAIL reset_res4: got %h want 0", res4); end
      n_cmp++; if (busy2 !== 1'b0) begin n_bad++; $display("FAIL reset_busy2: got %b want 0", busy2); end
      n_cmp++; if (done2 !== 1'b0) begin n_bad++; $display("FAIL reset_done2: got %b want 0", done2); end
      n_cmp++; if (res2 !== '0) begin n_bad++; $display("FAIL reset_res2: got %h want 0", res2); end
      reset = 1'b0;
      for (int e = 0; e < 16; e++) mr[e] = 0;
   endtask

   task automatic test_identity();
      logic [511:0] av, bv;
      int dc; logic b1, bd;
      av = '0;
      for (int i = 0; i < 4; i++) av[(i*4+i)*32 +: 32] = FP_ONE;
      for (int e = 0; e < 16; e++) bv[e*32 +: 32] = i2f(e + 1);
      for (int e = 0; e < 16; e++) begin
         ma[e] = ((e / 4) == (e % 4)) ? 1 : 0;
         mb[e] = e + 1;
      end
      model_step(1'b0);
      run4(av, bv, 1'b0, 1'b0, -1, -1, dc, b1, bd);
      n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL ident_busy_c1: got %b want 1", b1); end
      n_cmp++; if (dc != 26) begin n_bad++; $display("FAIL ident_done_cycle: got %0d want 26", dc); end
      n_cmp++; if (bd !== 1'b0) begin n_bad++; $display("FAIL ident_busy_at_done: got %b want 0", bd); end
      n_cmp++; if (res4 !== bv) begin n_bad++; $display("FAIL ident_res: got %h want %h", res4, bv); end
   endtask

   task automatic test_ones();
      int dc; logic b1, bd;
      for (int e = 0; e < 16; e++) begin ma[e] = 1; mb[e] = 1; end
      run4({16{FP_ONE}}, {16{FP_ONE}}, 1'b0, 1'b0, -1, -1, dc, b1, bd);
      n_cmp++; if (res4 !== {16{32'h40800000}}) begin n_bad++; $display("FAIL ones_acc0: got %h want all 40800000", res4); end
      run4({16{FP_ONE}}, {16{FP_ONE}}, 1'b1, 1'b0, -1, -1, dc, b1, bd);
      n_cmp++; if (res4 !== {16{32'h41000000}}) begin n_bad++; $display("FAIL ones_acc1: got %h want all 41000000", res4); end
      n_cmp++; if (dc != 26) begin n_bad++; $display("FAIL ones_acc1_done_cycle: got %0d want 26", dc); end
      for (int e = 0; e < 16; e++) mr[e] = 8;
   endtask

   task automatic test_random();
      int dc; logic b1, bd; bit acc;
      for (int it = 0; it < 5; it++) begin
         rand_mats();
         acc = (it == 0) ? 1'b0 : 1'($urandom_range(1));
         model_step(acc);
         run4(pack4(ma), pack4(mb), acc, 1'b0, -1, -1, dc, b1, bd);
         n_cmp++; if (dc != 26) begin n_bad++; $display("FAIL rand%0d_done_cycle: got %0d want 26", it, dc); end
         n_cmp++; if (res4 !== pack4(mr)) begin n_bad++; $display("FAIL rand%0d_res acc=%0d: got %h want %h", it, acc, res4, pack4(mr)); end
      end
   endtask

   task automatic test_ignored_start();
      int dc; logic b1, bd;
      rand_mats();
      model_step(1'b0);
      run4(pack4(ma), pack4(mb), 1'b0, 1'b0, 5, 12, dc, b1, bd);
      n_cmp++; if (dc != 26) begin n_bad++; $display("FAIL ignstart_done_cycle: got %0d want 26", dc); end
      n_cmp++; if (res4 !== pack4(mr)) begin n_bad++; $display("FAIL ignstart_res: got %h want %h", res4, pack4(mr)); end
   endtask

   task automatic test_reset_mid();
      int dc; logic b1, bd; bit seen;
      rand_mats();
      @(posedge clk); #1;
      a4 = pack4(ma); b4 = pack4(mb); acc4 = 1'b1; start4 = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         start4 = 1'b0;
      end
      n_cmp++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_c10: got %b want 1", busy4); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy4); end
      n_cmp++; if (res4 !== '0) begin n_bad++; $display("FAIL rstmid_res: got %h want 0", res4); end
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done4) seen = 1'b1;
      end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done: got %b want 0", seen); end
      for (int e = 0; e < 16; e++) mr[e] = 0;
      rand_mats();
      model_step(1'b1);
      run4(pack4(ma), pack4(mb), 1'b1, 1'b0, -1, -1, dc, b1, bd);
      n_cmp++; if (dc != 26) begin n_bad++; $display("FAIL rstmid_rerun_done_cycle: got %0d want 26", dc); end
      n_cmp++; if (res4 !== pack4(mr)) begin n_bad++; $display("FAIL rstmid_rerun_res: got %h want %h", res4, pack4(mr)); end
   endtask

   task automatic test_n2();
      logic [127:0] av, bv, ex;
      int dc;
      av = {i2f(4), i2f(3), i2f(2), i2f(1)};
      bv = {i2f(8), i2f(7), i2f(6), i2f(5)};
      for (int pass = 0; pass < 2; pass++) begin
         ex = (pass == 0) ? {32'h42480000, 32'h422C0000, 32'h41B00000, 32'h41980000}
                          : {i2f(100), i2f(86), i2f(44), i2f(38)};
         @(posedge clk); #1;
         a2 = av; b2 = bv; acc2 = 1'(pass); start2 = 1'b1;
         dc = -1;
         for (int cyc = 1; cyc < 30; cyc++) begin
            @(posedge clk); #1;
            start2 = 1'b0;
            a2 = {4{$urandom()}};
            b2 = {4{$urandom()}};
            if (done2) begin dc = cyc; break; end
         end
         n_cmp++; if (dc != 3) begin n_bad++; $display("FAIL n2_pass%0d_done_cycle: got %0d want 3", pass, dc); end
         n_cmp++; if (res2 !== ex) begin n_bad++; $display("FAIL n2_pass%0d_res: got %h want %h", pass, res2, ex); end
      end
   endtask

   task automatic test_back_to_back();
      int dc; logic b1, bd; bit acc;
      rand_mats();
      model_step(1'b0);
      run4(pack4(ma), pack4(mb), 1'b0, 1'b0, -1, -1, dc, b1, bd);
      n_cmp++; if (res4 !== pack4(mr)) begin n_bad++; $display("FAIL b2b_first_res: got %h want %h", res4, pack4(mr)); end
      rand_mats();
      acc = 1'($urandom_range(1));
      model_step(acc);
      run4(pack4(ma), pack4(mb), acc, 1'b1, -1, -1, dc, b1, bd);
      n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_after_start: got %b want 1", b1); end
      n_cmp++; if (dc != 26) begin n_bad++; $display("FAIL b2b_second_done: got %0d want 26", dc); end
      n_cmp++; if (res4 !== pack4(mr)) begin n_bad++; $display("FAIL b2b_second_res: got %h want %h", res4, pack4(mr)); end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_ones();
      test_random();
      test_ignored_start();
      test_reset_mid();
      test_n2();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
